// File: rtl/mul_pkg.sv
// Shared types and constants for the shift-add multiplier.
// Optional build macro: MUL_RADIX4_EN (two multiplier bits retired per iteration).
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  localparam int MUL_WIDTH = 16;

`ifdef MUL_RADIX4_EN
  localparam int MUL_BITS_PER_ITER = 2;
`else
  localparam int MUL_BITS_PER_ITER = 1;
`endif

  // Number of RUN cycles needed to consume every multiplier bit.
  function automatic int mul_iters(input int width);
    return width / MUL_BITS_PER_ITER;
  endfunction

  localparam int MUL_ITERS = mul_iters(MUL_WIDTH);

endpackage

// File: rtl/mul_unit_if.sv
// Request/result bundle between the ALU multiply path and mul_unit.
interface mul_unit_if #(
  parameter int WIDTH = 16
);
  logic               start;
  logic [WIDTH-1:0]   mul1;
  logic [WIDTH-1:0]   mul2;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] mulresult;

  modport master (
    output start, mul1, mul2,
    input  busy, done, mulresult
  );

  modport slave (
    input  start, mul1, mul2,
    output busy, done, mulresult
  );
endinterface

// File: rtl/mul_step.sv
// One add-and-shift iteration of the multiplier datapath (purely combinational).
// Optional build macro: MUL_RADIX4_EN selects 0/A/2A/3A from two multiplier bits.
module mul_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   a,
`ifdef MUL_RADIX4_EN
  input  logic [WIDTH+1:0]   a3,
`endif
  output logic [WIDTH-1:0]   acc_nxt,
  output logic [WIDTH-1:0]   b_nxt
);

`ifdef MUL_RADIX4_EN
  logic [WIDTH+1:0] addend;
  logic [WIDTH+1:0] sum;

  // Pick the partial product from the two low multiplier bits.
  always_comb begin
    addend = '0;
    unique case (b[1:0])
      2'd0:    addend = '0;
      2'd1:    addend = {2'b00, a};
      2'd2:    addend = {1'b0, a, 1'b0};
      default: addend = a3;
    endcase
  end

  // acc + 3A fits in WIDTH+2 bits, and after the 2-bit shift acc fits in WIDTH again.
  assign sum     = {2'b00, acc} + addend;
  assign acc_nxt = sum[WIDTH+1:2];
  assign b_nxt   = {sum[1:0], b[WIDTH-1:2]};
`else
  logic [WIDTH:0] sum;

  assign sum     = {1'b0, acc} + (b[0] ? {1'b0, a} : {(WIDTH+1){1'b0}});
  assign acc_nxt = sum[WIDTH:1];
  assign b_nxt   = {sum[0], b[WIDTH-1:1]};
`endif

endmodule

// File: rtl/mul_unit.sv
// Iterative unsigned shift-add multiplier; product returned with a one-cycle done pulse.
// Optional build macro: MUL_RADIX4_EN (radix-4 iterations, half the latency).
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one add-and-shift per cycle, busy high
// DONE  | done pulse cycle, result valid; start here chains a new product
module mul_unit
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input logic       clk,
  input logic       rst_n,
  mul_unit_if.slave bus
);

  localparam int ITERS = mul_iters(WIDTH);
  localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

  mul_state_t          state;
  logic [WIDTH-1:0]    a;
  logic [WIDTH-1:0]    b;
  logic [WIDTH-1:0]    acc;
  logic [CNT_W-1:0]    cnt;
  logic                busy_q;
  logic                done_q;
  logic [2*WIDTH-1:0]  result_q;
  logic [WIDTH-1:0]    acc_nxt;
  logic [WIDTH-1:0]    b_nxt;
  logic                last;
`ifdef MUL_RADIX4_EN
  logic [WIDTH+1:0]    a3;
`endif

  assign last = (cnt == CNT_W'(ITERS - 1));

  mul_step #(.WIDTH(WIDTH)) u_step (
    .acc     (acc),
    .b       (b),
    .a       (a),
`ifdef MUL_RADIX4_EN
    .a3      (a3),
`endif
    .acc_nxt (acc_nxt),
    .b_nxt   (b_nxt)
  );

  // Control FSM and datapath registers; the product only updates on the completion edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a        <= '0;
      b        <= '0;
      acc      <= '0;
      cnt      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
`ifdef MUL_RADIX4_EN
      a3       <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            a      <= bus.mul1;
            b      <= bus.mul2;
            acc    <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
`ifdef MUL_RADIX4_EN
            a3     <= {1'b0, bus.mul1, 1'b0} + {2'b00, bus.mul1};
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          b   <= b_nxt;
          cnt <= cnt + CNT_W'(1);
          if (last) begin
            result_q <= {acc_nxt, b_nxt};
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.mulresult = result_q;

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed products plus randomized traffic
// against a cycle-level behavioural model (countdown + plain multiplication).
module tb_mul_unit;

`ifdef MUL_RADIX4_EN
  localparam int LAT   = 9;
`else
  localparam int LAT   = 17;
`endif
  localparam int NITER = LAT - 1;

  logic clk;
  logic rst_n;

  mul_unit_if #(.WIDTH(16)) bus ();

  mul_unit #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int dn_cnt   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: accepted start arms a countdown; product is plain multiplication.
  int          m_left;
  bit          m_done;
  logic [31:0] m_res;
  logic [31:0] m_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0;
      m_done = 0;
      m_res  = '0;
      m_pend = '0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      m_done = (m_left == 0);
      if (m_left == 0) m_res = m_pend;
    end else begin
      m_done = 0;
      if (bus.start) begin
        m_pend = 32'(bus.mul1) * 32'(bus.mul2);
        m_left = NITER;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    chk("busy", bus.busy, (m_left > 0));
    chk("done", bus.done, m_done);
    chk("mulresult", bus.mulresult, m_res);
    if (bus.busy && bus.done) chk("busy_done_overlap", 1, 0);
    if (bus.done) dn_cnt++;
  end

  function automatic logic [15:0] pick();
    int r;
    r = $urandom_range(0, 7);
    case (r)
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  // Issue one product from a negedge and wait (bounded) for done; optional mid-RUN start poke.
  task automatic do_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] exp, input int poke);
    int n;
    int nb;
    bit held;
    logic [31:0] r0;
    n    = 0;
    nb   = 0;
    held = 1;
    r0   = bus.mulresult;
    bus.start = 1'b1;
    bus.mul1  = a;
    bus.mul2  = b;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (poke > 0 && n == poke) begin
        bus.start = 1'b1;
        bus.mul1  = 16'hAAAA;
        bus.mul2  = 16'h5555;
      end else begin
        bus.start = 1'b0;
        bus.mul1  = 16'($urandom);
        bus.mul2  = 16'($urandom);
      end
      if (bus.busy) begin
        nb++;
        if (bus.mulresult !== r0) held = 0;
      end
    end while (!bus.done && n < 40);
    chk({nm, "_latency"}, 64'(n), 64'(LAT));
    chk({nm, "_busy_cycles"}, 64'(nb), 64'(NITER));
    chk({nm, "_result"}, bus.mulresult, exp);
    chk({nm, "_hold_during_run"}, held, 1);
  endtask

  initial begin
    int d0;
    int cyc;
    bus.start = 1'b0;
    bus.mul1  = '0;
    bus.mul2  = '0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_result", bus.mulresult, 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("3x5", 16'h0003, 16'h0005, 32'h0000000F, 0);
    // Back-to-back: start in the DONE cycle.
    do_op("b2b_ff_x_100", 16'h00FF, 16'h0100, 32'h0000FF00, 0);
    @(negedge clk);
    do_op("ffff_sq", 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 0);
    @(negedge clk);
    do_op("8000_sq", 16'h8000, 16'h8000, 32'h40000000, 0);
    @(negedge clk);
    do_op("zero", 16'h0000, 16'h1234, 32'h00000000, 0);
    @(negedge clk);

    // start poked mid-RUN must be ignored.
    d0 = dn_cnt;
    do_op("midrun_poke", 16'h1234, 16'h0010, 32'h00012340, 5);
    repeat (LAT + 3) @(negedge clk);
    chk("midrun_single_done", 64'(dn_cnt - d0), 1);

    // Reset at iteration 7.
    bus.start = 1'b1;
    bus.mul1  = 16'h1234;
    bus.mul2  = 16'h5678;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_done", bus.done, 0);
    chk("rst_mid_result", bus.mulresult, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    d0 = dn_cnt;
    repeat (LAT + 3) @(negedge clk);
    chk("rst_no_done", 64'(dn_cnt - d0), 0);
    chk("rst_idle_busy", bus.busy, 0);
    do_op("after_rst", 16'h1234, 16'h5678, 32'h06260060, 0);
    @(negedge clk);

    // Randomized traffic; model checks every cycle.
    d0  = dn_cnt;
    cyc = 0;
    while ((dn_cnt - d0) < 1000 && cyc < 60000) begin
      bus.start = ($urandom_range(0, 3) == 0);
      bus.mul1  = pick();
      bus.mul2  = pick();
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    chk("random_done_count", 64'((dn_cnt - d0) >= 1000), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
